// File: rtl/pakout_if.sv
// Four-phase request/acknowledge channel with a data payload.
// The master drives req and data; the slave answers with ack.
interface pakout_if #(
  parameter int DW = 1
) ();
  logic          req;
  logic          ack;
  logic [DW-1:0] data;

  modport master (output req, output data, input ack);
  modport slave  (input req, input data, output ack);
endinterface

// File: rtl/pakout.sv
// Packet serializer: accepts one wide {addr, cnt, words} packet on rcv0 and
// emits each word as an {addr, word} message on snd0 before releasing rcv0.
module pakout #(
  parameter int ASZ = 6,
  parameter int DSZ = 4,
  parameter int PKW = 4,
  parameter int CSZ = 3
) (
  input  logic     i_clk,
  input  logic     reset,
  output logic     ready,
  pakout_if.slave  rcv0,
  pakout_if.master snd0,
  output logic     err
);

  localparam int RW = ASZ + CSZ + PKW * DSZ;
  localparam int SW = ASZ + DSZ;
  localparam int IW = (PKW > 1) ? $clog2(PKW) : 1;

  typedef enum logic [1:0] {
    RCV_WAIT,
    SND_REQ,
    SND_REL,
    RCV_ACK
  } state_e;

  state_e                   state_q, state_d;
  logic [IW-1:0]            idx_q, idx_d;
  logic [CSZ-1:0]           eff_cnt_q, eff_cnt_d;
  logic [ASZ-1:0]           addr_q, addr_d;
  logic [PKW-1:0][DSZ-1:0]  words_q, words_d;
  logic                     snd_req_q, snd_req_d;
  logic [SW-1:0]            snd_data_q, snd_data_d;
  logic                     rcv_ack_q, rcv_ack_d;
  logic                     err_q, err_d;
  logic                     ready_q, ready_d;

  logic [ASZ-1:0]           in_addr;
  logic [CSZ-1:0]           in_cnt;
  logic [PKW-1:0][DSZ-1:0]  in_words;
  logic                     last_word;

  assign in_addr   = rcv0.data[RW-1 -: ASZ];
  assign in_cnt    = rcv0.data[PKW*DSZ +: CSZ];
  assign in_words  = rcv0.data[PKW*DSZ-1:0];
  assign last_word = (CSZ'(idx_q) == eff_cnt_q - CSZ'(1));

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case
    // leaves one unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    idx_d      = idx_q;
    eff_cnt_d  = eff_cnt_q;
    addr_d     = addr_q;
    words_d    = words_q;
    snd_req_d  = snd_req_q;
    snd_data_d = snd_data_q;
    rcv_ack_d  = rcv_ack_q;
    err_d      = err_q;

    unique case (state_q)
      RCV_WAIT: begin
        if (rcv0.req) begin
          addr_d  = in_addr;
          words_d = in_words;
          idx_d   = '0;
          if (in_cnt == '0) begin
            state_d = RCV_ACK;
          end else begin
            eff_cnt_d = (in_cnt > CSZ'(PKW)) ? CSZ'(PKW) : in_cnt;
            err_d     = err_q | (in_cnt > CSZ'(PKW));
            state_d   = SND_REQ;
          end
        end
      end
      // req is raised one cycle into the state, so an ack that is already
      // high on entry is only honoured after req has actually been driven.
      SND_REQ: begin
        if (!snd_req_q) begin
          snd_req_d  = 1'b1;
          snd_data_d = {addr_q, words_q[idx_q]};
        end else if (snd0.ack) begin
          snd_req_d = 1'b0;
          state_d   = SND_REL;
        end
      end
      SND_REL: begin
        if (!snd0.ack) begin
          if (last_word) begin
            state_d = RCV_ACK;
          end else begin
            idx_d   = idx_q + IW'(1);
            state_d = SND_REQ;
          end
        end
      end
      RCV_ACK: begin
        if (!rcv_ack_q) begin
          rcv_ack_d = 1'b1;
        end else if (!rcv0.req) begin
          rcv_ack_d = 1'b0;
          state_d   = RCV_WAIT;
        end
      end
      default: state_d = RCV_WAIT;
    endcase

    ready_d = (state_d == RCV_WAIT);
  end

  // NOTE: non-blocking assignments in clocked blocks so every flop samples
  // the pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge i_clk) begin
    if (reset) begin
      state_q    <= RCV_WAIT;
      idx_q      <= '0;
      snd_req_q  <= 1'b0;
      snd_data_q <= '0;
      rcv_ack_q  <= 1'b0;
      err_q      <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      snd_req_q  <= snd_req_d;
      snd_data_q <= snd_data_d;
      rcv_ack_q  <= rcv_ack_d;
      err_q      <= err_d;
      ready_q    <= ready_d;
    end
  end

  // NOTE: the captured packet is plain payload, always written before it is
  // read, so it is deliberately left out of reset.
  always_ff @(posedge i_clk) begin
    addr_q    <= addr_d;
    words_q   <= words_d;
    eff_cnt_q <= eff_cnt_d;
  end

  assign ready     = ready_q;
  assign err       = err_q;
  assign snd0.req  = snd_req_q;
  assign snd0.data = snd_data_q;
  assign rcv0.ack  = rcv_ack_q;

endmodule

// File: tb/tb_pakout.sv
// Self-checking bench for pakout: a vector table of packets, a scoreboard of
// expected messages and a responding snd0 sink with configurable ack delay.
module tb_pakout;

  localparam int ASZ = 6;
  localparam int DSZ = 4;
  localparam int PKW = 4;
  localparam int CSZ = 3;
  localparam int RW  = ASZ + CSZ + PKW * DSZ;
  localparam int SW  = ASZ + DSZ;

  typedef struct {
    logic [ASZ-1:0]     addr;
    logic [CSZ-1:0]     cnt;
    logic [PKW*DSZ-1:0] words;
    int                 delay;
    bit                 scramble;
    logic               exp_err;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  logic ready;
  logic err;

  pakout_if #(.DW(RW)) rcv_if ();
  pakout_if #(.DW(SW)) snd_if ();

  pakout #(.ASZ(ASZ), .DSZ(DSZ), .PKW(PKW), .CSZ(CSZ)) dut (
    .i_clk (clk),
    .reset (reset),
    .ready (ready),
    .rcv0  (rcv_if),
    .snd0  (snd_if),
    .err   (err)
  );

  vec_t          vecs[9];
  logic [SW-1:0] exp_q[$];
  int            total = 0;
  int            bad = 0;
  int            cyc = 0;
  int            ack_delay = 1;
  int            msg_seen = 0;
  bit            first_pending = 1'b0;
  int            t_req = 0;
  int            first_lat = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void push_expected(input vec_t v);
    int n;
    n = (int'(v.cnt) > PKW) ? PKW : int'(v.cnt);
    for (int i = 0; i < n; i++) exp_q.push_back({v.addr, v.words[i*DSZ +: DSZ]});
  endfunction

  // snd0 sink: checks each message against the scoreboard, holds ack off for
  // ack_delay cycles while watching that req/data stay put, then completes.
  initial begin
    logic [SW-1:0] held;
    bit            ok;
    bit            aborted;
    int            dly;
    snd_if.ack = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset && snd_if.req && !snd_if.ack) begin
        held = snd_if.data;
        msg_seen++;
        if (first_pending) begin
          first_lat     = cyc - t_req;
          first_pending = 1'b0;
        end
        check("msg_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) check("msg_data", held, exp_q.pop_front());
        ok      = 1'b1;
        aborted = 1'b0;
        dly     = ack_delay;
        for (int i = 0; i < dly; i++) begin
          @(negedge clk);
          if (reset) begin
            aborted = 1'b1;
            break;
          end
          if (!(snd_if.req === 1'b1 && snd_if.data === held && rcv_if.ack === 1'b0)) ok = 1'b0;
        end
        if (!aborted) begin
          check("hold_stable", ok, 1);
          snd_if.ack = 1'b1;
          for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (!snd_if.req || reset) break;
          end
          check("snd_req_release", snd_if.req, 0);
          snd_if.ack = 1'b0;
        end
      end
    end
  end

  task automatic run_packet(input int k);
    vec_t v;
    bit   got;
    v = vecs[k];
    for (int i = 0; i < 100 && !ready; i++) @(negedge clk);
    check("ready_before_pkt", ready, 1);
    push_expected(v);
    ack_delay     = v.delay;
    rcv_if.data   = {v.addr, v.cnt, v.words};
    rcv_if.req    = 1'b1;
    t_req         = cyc;
    first_pending = (v.cnt != '0);
    if (v.scramble) begin
      @(negedge clk);
      rcv_if.data = ~rcv_if.data;
    end
    got = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (rcv_if.ack) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("rcv_ack_seen", got, 1);
    if (v.cnt == '0) check("zero_cnt_ack_latency", (cyc - t_req) <= 2, 1);
    else             check("first_msg_latency", first_lat, 2);
    check("all_words_sent", exp_q.size(), 0);
    check("snd_idle_at_rcv_ack", {snd_if.req, snd_if.ack}, 0);
    check("err_flag", err, v.exp_err);
    rcv_if.req = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!rcv_if.ack) begin
        got = 1'b1;
        break;
      end
    end
    check("rcv_ack_release", got, 1);
    check("ready_after_pkt", ready, 1);
  endtask

  task automatic reset_mid_packet();
    vec_t v;
    int   base;
    v    = '{6'h2C, 3'd4, 16'hABCD, 30, 1'b0, 1'b0};
    base = msg_seen;
    push_expected(v);
    ack_delay   = v.delay;
    rcv_if.data = {v.addr, v.cnt, v.words};
    rcv_if.req  = 1'b1;
    for (int i = 0; i < 200 && (msg_seen - base) < 2; i++) @(negedge clk);
    check("reached_word1", msg_seen - base, 2);
    @(negedge clk);
    check("word1_pending", snd_if.req, 1);
    reset      = 1'b1;
    rcv_if.req = 1'b0;
    @(negedge clk);
    check("rst_snd_req", snd_if.req, 0);
    check("rst_rcv_ack", rcv_if.ack, 0);
    check("rst_err", err, 0);
    check("rst_ready", ready, 0);
    check("rst_words_dropped", exp_q.size(), 2);
    exp_q.delete();
    reset = 1'b0;
    @(negedge clk);
    check("ready_after_mid_reset", ready, 1);
    check("snd_idle_after_mid_reset", snd_if.req, 0);
  endtask

  initial begin
    vecs[0] = '{6'h15, 3'd3, 16'h0A5C, 1,  1'b0, 1'b0};
    vecs[1] = '{6'h2A, 3'd0, 16'h1234, 1,  1'b0, 1'b0};
    vecs[2] = '{6'h3F, 3'd4, 16'hFEDC, 0,  1'b0, 1'b0};
    vecs[3] = '{6'h01, 3'd5, 16'h4321, 2,  1'b0, 1'b1};
    vecs[4] = '{6'h10, 3'd2, 16'h00BA, 1,  1'b1, 1'b1};
    vecs[5] = '{6'h07, 3'd1, 16'h0009, 20, 1'b0, 1'b1};
    vecs[6] = '{6'h22, 3'd4, 16'h1357, 1,  1'b0, 1'b0};
    vecs[7] = '{6'h33, 3'd3, 16'h8642, 0,  1'b0, 1'b0};
    vecs[8] = '{6'h3A, 3'd7, 16'h9BDF, 1,  1'b0, 1'b1};

    reset       = 1'b1;
    rcv_if.req  = 1'b0;
    rcv_if.data = '0;
    repeat (3) @(negedge clk);
    check("reset_ready", ready, 0);
    check("reset_snd_req", snd_if.req, 0);
    check("reset_snd_data", snd_if.data, 0);
    check("reset_rcv_ack", rcv_if.ack, 0);
    check("reset_err", err, 0);
    reset = 1'b0;
    @(negedge clk);
    check("ready_after_reset", ready, 1);

    for (int k = 0; k < 6; k++) run_packet(k);
    reset_mid_packet();
    for (int k = 6; k < 9; k++) run_packet(k);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
